guess_history: RTL

Parametrised turn-history buffer for the Mastermind game. It records every committed guess together with its exact/partial feedback score, up to `MAX_TURNS` turns. In guess mode it presents the newest entry to the display and feedback path; in browse mode the player steps through stored turns with up/down buttons. It sits between the guess-entry/debounce logic and the seven-segment/LED display mux, and also reports game-over to the top-level controller.

---
 rtl/mastermind_pkg.sv | 21 ++
 rtl/guess_history_if.sv | 44 ++++
 rtl/history_store.sv | 33 +++
 rtl/guess_history.sv | 103 ++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared Mastermind constants, mode encodings and the turn-history entry layout.
package mastermind_pkg;

  localparam int unsigned NUM_PEGS_DEF  = 4;
  localparam int unsigned COLOR_W_DEF   = 3;
  localparam int unsigned MAX_TURNS_DEF = 8;
  localparam int unsigned FB_W_DEF      = $clog2(NUM_PEGS_DEF + 1);

  localparam logic MODE_GUESS  = 1'b0;
  localparam logic MODE_BROWSE = 1'b1;

  // Entry layout at default sizing; the history store keeps this field order.
  typedef struct packed {
    logic [NUM_PEGS_DEF*COLOR_W_DEF-1:0] guess;
    logic [FB_W_DEF-1:0]                 exact;
    logic [FB_W_DEF-1:0]                 partial;
  } entry_t;

  localparam int unsigned ENTRY_W_DEF = $bits(entry_t);

endpackage

// File: rtl/guess_history_if.sv
// Guess-entry side and display side signals of the turn-history buffer.
interface guess_history_if #(
  parameter int unsigned NUM_PEGS  = mastermind_pkg::NUM_PEGS_DEF,
  parameter int unsigned COLOR_W   = mastermind_pkg::COLOR_W_DEF,
  parameter int unsigned MAX_TURNS = mastermind_pkg::MAX_TURNS_DEF
);
  localparam int unsigned IDX_W   = $clog2(MAX_TURNS);
  localparam int unsigned CNT_W   = $clog2(MAX_TURNS + 1);
  localparam int unsigned FB_W    = $clog2(NUM_PEGS + 1);
  localparam int unsigned GUESS_W = NUM_PEGS * COLOR_W;

  logic               mode;
  logic               btn_up;
  logic               btn_down;
  logic               btn_select;
  logic [GUESS_W-1:0] guess;
  logic [FB_W-1:0]    fb_exact;
  logic [FB_W-1:0]    fb_partial;

  logic [GUESS_W-1:0] sel_guess;
  logic [FB_W-1:0]    sel_exact;
  logic [FB_W-1:0]    sel_partial;
  logic [IDX_W-1:0]   sel_turn;
  logic               sel_valid;
  logic [CNT_W-1:0]   turn_count;
  logic               last_turn;
  logic               full;
  logic               game_won;
  logic               store_ack;
  logic               store_rej;

  modport master (
    output mode, btn_up, btn_down, btn_select, guess, fb_exact, fb_partial,
    input  sel_guess, sel_exact, sel_partial, sel_turn, sel_valid, turn_count,
           last_turn, full, game_won, store_ack, store_rej
  );

  modport slave (
    input  mode, btn_up, btn_down, btn_select, guess, fb_exact, fb_partial,
    output sel_guess, sel_exact, sel_partial, sel_turn, sel_valid, turn_count,
           last_turn, full, game_won, store_ack, store_rej
  );

endinterface

// File: rtl/history_store.sv
// Register-array turn store: synchronous write, registered read, async clear.
module history_store #(
  parameter int unsigned ENTRY_W = mastermind_pkg::ENTRY_W_DEF,
  parameter int unsigned DEPTH   = mastermind_pkg::MAX_TURNS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [ENTRY_W-1:0]         rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data is forced to zero while the history is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
    else            rdata <= '0;
  end

endmodule

// File: rtl/guess_history.sv
// Mastermind turn-history buffer: commit counter, selection pointer, game flags.
module guess_history
  import mastermind_pkg::*;
#(
  parameter int unsigned NUM_PEGS  = NUM_PEGS_DEF,
  parameter int unsigned COLOR_W   = COLOR_W_DEF,
  parameter int unsigned MAX_TURNS = MAX_TURNS_DEF
) (
  input logic            clk,
  input logic            reset,
  guess_history_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(MAX_TURNS);
  localparam int unsigned CNT_W   = $clog2(MAX_TURNS + 1);
  localparam int unsigned FB_W    = $clog2(NUM_PEGS + 1);
  localparam int unsigned GUESS_W = NUM_PEGS * COLOR_W;
  localparam int unsigned ENTRY_W = GUESS_W + 2 * FB_W;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               won_q, won_d;
  logic               full_q, full_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic               rej_q, rej_d;
  logic               commit, accept, browse;
  logic [ENTRY_W-1:0] rdata;

  // Next-state for counter, selection pointer and flags.
  always_comb begin
    commit  = (bus.mode == MODE_GUESS) && bus.btn_select;
    browse  = (bus.mode == MODE_BROWSE);
    accept  = commit && !full_q && !won_q;
    count_d = accept ? count_q + CNT_W'(1) : count_q;
    won_d   = won_q || (accept && (bus.fb_exact == FB_W'(NUM_PEGS)));
    ack_d   = accept;
    rej_d   = commit && !accept;
    full_d  = (count_d == CNT_W'(MAX_TURNS));
    last_d  = (count_d == CNT_W'(MAX_TURNS - 1));
    valid_d = (count_d != '0);
    sel_d   = sel_q;
    if (!browse) begin
      if (accept)              sel_d = IDX_W'(count_q);
      else if (count_q != '0)  sel_d = IDX_W'(count_q - CNT_W'(1));
      else                     sel_d = '0;
    end else if (bus.btn_up && !bus.btn_down) begin
      if (CNT_W'(sel_q) + CNT_W'(1) < count_q) sel_d = sel_q + IDX_W'(1);
    end else if (bus.btn_down && !bus.btn_up) begin
      if (sel_q != '0) sel_d = sel_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sel_q   <= '0;
      won_q   <= 1'b0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sel_q   <= sel_d;
      won_q   <= won_d;
      full_q  <= full_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
    end
  end

  history_store #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (MAX_TURNS)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (IDX_W'(count_q)),
    .wdata ({bus.guess, bus.fb_exact, bus.fb_partial}),
    .rd_en (count_q != '0),
    .raddr (sel_q),
    .rdata (rdata)
  );

  assign bus.sel_guess   = rdata[ENTRY_W-1:2*FB_W];
  assign bus.sel_exact   = rdata[2*FB_W-1:FB_W];
  assign bus.sel_partial = rdata[FB_W-1:0];
  assign bus.sel_turn    = sel_q;
  assign bus.sel_valid   = valid_q;
  assign bus.turn_count  = count_q;
  assign bus.last_turn   = last_q;
  assign bus.full        = full_q;
  assign bus.game_won    = won_q;
  assign bus.store_ack   = ack_q;
  assign bus.store_rej   = rej_q;

endmodule
